// File: rtl/clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : clk_rst_seq
// Brief   : PLL-lock driven reset sequencer; releases sys_resetn after lock has
//           been stable for HOLD_CYCLES and counts lock-loss events.
//           Optional loss counter enabled by macro CLKRST_LOSS_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module clk_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               pll_lock,
  input  logic               clear_loss,
  output logic               sys_resetn,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] loss_count
);

  localparam int C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t                 r_state;
  logic [C_HOLD_W-1:0]    r_hold_cnt;
  logic                   r_sys_resetn;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  // pll_lock is asynchronous; only the last synchronizer stage is ever used
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_sys_resetn <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          r_hold_cnt   <= '0;
          r_sys_resetn <= 1'b0;
          if (w_lock_s) begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!w_lock_s) begin
            r_state      <= S_WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_sys_resetn <= 1'b0;
          end else if (r_hold_cnt == C_HOLD_LAST) begin
            r_state      <= S_RUN;
            r_hold_cnt   <= '0;
            r_sys_resetn <= 1'b1;
          end else begin
            r_hold_cnt   <= r_hold_cnt + C_HOLD_W'(1);
            r_sys_resetn <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            r_state      <= S_WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_sys_resetn <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_WAIT_LOCK;
          r_hold_cnt   <= '0;
          r_sys_resetn <= 1'b0;
        end
      endcase
    end
  end

  assign sys_resetn = r_sys_resetn;
  assign state      = r_state;

`ifdef CLKRST_LOSS_COUNT_EN
  logic [COUNT_W-1:0] r_loss_count;
  logic               w_loss_evt;

  assign w_loss_evt = (r_state == S_RUN) && !w_lock_s;

  // A clear coinciding with a loss keeps that loss: the count restarts at 1
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_loss_count <= '0;
    end else if (clear_loss && w_loss_evt) begin
      r_loss_count <= COUNT_W'(1);
    end else if (clear_loss) begin
      r_loss_count <= '0;
    end else if (w_loss_evt && (r_loss_count != '1)) begin
      r_loss_count <= r_loss_count + COUNT_W'(1);
    end
  end

  assign loss_count = r_loss_count;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_loss;
  assign loss_count     = '0;
`endif

endmodule
`default_nettype wire
